// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 5-bit opcode constants used by the ALU and by the
// control decoder, and the shift-type encoding for the barrel shifter.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;

  // ALUOPCtrl encodings; codes 14..31 are undefined and produce zero.
  localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALU_ADDU = 5'd1;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'd2;
  localparam logic [OP_W-1:0] ALU_SUBU = 5'd3;
  localparam logic [OP_W-1:0] ALU_AND  = 5'd4;
  localparam logic [OP_W-1:0] ALU_OR   = 5'd5;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'd6;
  localparam logic [OP_W-1:0] ALU_NOR  = 5'd7;
  localparam logic [OP_W-1:0] ALU_SLT  = 5'd8;
  localparam logic [OP_W-1:0] ALU_SLTU = 5'd9;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'd10;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'd11;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'd12;
  localparam logic [OP_W-1:0] ALU_LUI  = 5'd13;

  // Barrel shifter operation select.
  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2
  } shift_type_e;

endpackage

// File: rtl/alu_shifter.sv
// 32-bit barrel shifter for SLL/SRL/SRA. Only the 5-bit amount is seen here,
// so any wider shift count has already been reduced modulo 32 by the caller.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [4:0]        amount,
  input  shift_type_e       shift_type,
  output logic [DATA_W-1:0] result
);

  // Select the shift flavour; SRA replicates the sign bit of the value.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    result = '0;
    case (shift_type)
      SHIFT_SLL: result = value << amount;
      SHIFT_SRL: result = value >> amount;
      SHIFT_SRA: result = DATA_W'($signed(value) >>> amount);
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// MIPS datapath ALU: combinational result/zero/ovf from two 32-bit operands
// and a 5-bit opcode, plus one registered sticky overflow status bit.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  input  logic [OP_W-1:0]   ALUOPCtrl,
  output logic              zero,
  output logic              ovf,
  output logic [DATA_W-1:0] aluout,
  output logic              ovf_sticky
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic              slt_bit;
  logic              sltu_bit;
  logic [DATA_W-1:0] shift_out;
  shift_type_e       shift_type;
  logic              ovf_sticky_d;
  logic              ovf_sticky_q;

  // Wrapped sum/difference and their signed-overflow conditions.
  always_comb begin
    sum     = srcA + srcB;
    diff    = srcA - srcB;
    add_ovf = (srcA[31] == srcB[31]) && (sum[31]  != srcA[31]);
    sub_ovf = (srcA[31] != srcB[31]) && (diff[31] != srcA[31]);
    // True signed compare, independent of any overflow in diff.
    slt_bit  = $signed(srcA) < $signed(srcB);
    sltu_bit = srcA < srcB;
  end

  // Map the opcode onto the shifter's type select; non-shift ops don't care.
  always_comb begin
    shift_type = SHIFT_SLL;
    case (ALUOPCtrl)
      ALU_SRL: shift_type = SHIFT_SRL;
      ALU_SRA: shift_type = SHIFT_SRA;
      default: shift_type = SHIFT_SLL;
    endcase
  end

  alu_shifter u_shifter (
    .value      (srcB),
    .amount     (srcA[4:0]),
    .shift_type (shift_type),
    .result     (shift_out)
  );

  // Result mux; undefined opcodes yield zero with no overflow.
  always_comb begin
    aluout = '0;
    ovf    = 1'b0;
    case (ALUOPCtrl)
      ALU_ADD:  begin aluout = sum;  ovf = add_ovf; end
      ALU_ADDU: aluout = sum;
      ALU_SUB:  begin aluout = diff; ovf = sub_ovf; end
      ALU_SUBU: aluout = diff;
      ALU_AND:  aluout = srcA & srcB;
      ALU_OR:   aluout = srcA | srcB;
      ALU_XOR:  aluout = srcA ^ srcB;
      ALU_NOR:  aluout = ~(srcA | srcB);
      ALU_SLT:  aluout = {31'b0, slt_bit};
      ALU_SLTU: aluout = {31'b0, sltu_bit};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  aluout = shift_out;
      ALU_LUI:  aluout = {srcB[15:0], 16'h0000};
      default:  begin aluout = '0; ovf = 1'b0; end
    endcase
  end

  assign zero = (aluout == '0);

  // Next sticky value accumulates any overflow seen this cycle.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q | ovf;
  end

  // Sticky status register; reset wins over a simultaneous overflow.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) ovf_sticky_q <= 1'b0;
    else     ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: stimulus is driven after each posedge with the
// expected result pushed to a scoreboard, and popped/compared on the negedge.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [4:0]  ALUOPCtrl;
  logic        zero;
  logic        ovf;
  logic [31:0] aluout;
  logic        ovf_sticky;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t sb_e;
  logic cur_ovf_m = 1'b0;
  logic sticky_m  = 1'b0;
  bit   sticky_en = 1'b0;

  always #5 clk = ~clk;

  alu u_dut (
    .clk        (clk),
    .rst        (rst),
    .srcA       (srcA),
    .srcB       (srcB),
    .ALUOPCtrl  (ALUOPCtrl),
    .zero       (zero),
    .ovf        (ovf),
    .aluout     (aluout),
    .ovf_sticky (ovf_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Golden model built on 64-bit signed arithmetic.
  function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic v);
    longint sa;
    longint sb;
    longint w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    w  = 0;
    r  = 32'h0;
    v  = 1'b0;
    case (op)
      5'd0, 5'd1: begin
        w = sa + sb;
        r = w[31:0];
        v = (op == 5'd0) && (w > 64'sd2147483647 || w < -64'sd2147483648);
      end
      5'd2, 5'd3: begin
        w = sa - sb;
        r = w[31:0];
        v = (op == 5'd2) && (w > 64'sd2147483647 || w < -64'sd2147483648);
      end
      5'd4:  r = a & b;
      5'd5:  r = a | b;
      5'd6:  r = a ^ b;
      5'd7:  r = ~(a | b);
      5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  r = ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
      5'd10: r = b << a[4:0];
      5'd11: r = b >> a[4:0];
      5'd12: begin w = sb >>> a[4:0]; r = w[31:0]; end
      5'd13: r = {b[15:0], 16'h0000};
      default: r = 32'h0;
    endcase
  endfunction

  // Reference sticky bit, updated from the bench's own expected ovf.
  always @(posedge clk) begin
    if (rst) sticky_m <= 1'b0;
    else     sticky_m <= sticky_m | cur_ovf_m;
    sticky_en <= 1'b1;
  end

  // Compare outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sticky_en) check("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, sticky_m});
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      check({sb_e.tag, ".aluout"}, aluout, sb_e.res);
      check({sb_e.tag, ".zero"}, {31'b0, zero}, {31'b0, (sb_e.res == 32'h0)});
      check({sb_e.tag, ".ovf"}, {31'b0, ovf}, {31'b0, sb_e.ovf});
    end
  end

  task automatic drive(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_ovf, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    ALUOPCtrl = op;
    srcA      = a;
    srcB      = b;
    cur_ovf_m = exp_ovf;
    e.tag = tag;
    e.res = exp_res;
    e.ovf = exp_ovf;
    sb_q.push_back(e);
  endtask

  initial begin
    logic [31:0] specials [6];
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [4:0]  op;
    logic        v;
    logic        rr;

    specials = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0020};
    rst = 1'b1; srcA = '0; srcB = '0; ALUOPCtrl = ALU_ADD;
    repeat (2) @(posedge clk);

    // Directed cases with hand-derived expectations.
    drive("add_ovf",   ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0);
    drive("addu",      ALU_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0);
    drive("sub_zero",  ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0);
    drive("sub_ovf",   ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0);
    drive("slt",       ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    drive("sltu",      ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    drive("sra",       ALU_SRA,  32'h0000_0004, 32'hF000_0000, 32'hFF00_0000, 1'b0, 1'b0);
    drive("srl",       ALU_SRL,  32'h0000_0004, 32'hF000_0000, 32'h0F00_0000, 1'b0, 1'b0);
    drive("sll_wrap",  ALU_SLL,  32'h0000_0021, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    drive("lui",       ALU_LUI,  32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0);
    drive("nor",       ALU_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drive("and",       ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0);
    drive("xor",       ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0);
    drive("op31",      5'd31,    32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b0);
    drive("op14",      5'd14,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    // Reset coinciding with an overflow must clear the sticky bit.
    drive("rst_ovf",   ALU_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
    drive("post_rst",  ALU_OR,   32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);

    // Random sweep across all opcodes, mixing in corner operands.
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rr = ($urandom_range(0, 31) == 0);
      model(op, a, b, r, v);
      drive("rand", op, a, b, r, v, rr);
    end

    @(posedge clk);
    #1;
    rst = 1'b0;
    ALUOPCtrl = ALU_ADDU;
    cur_ovf_m = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Combinational 32-bit integer ALU for the MIPS CPU datapath, sitting between the register-file/immediate operand muxes and the writeback/branch logic. Given two operands and a 5-bit operation code, it produces the result, a zero flag (used for branches), and a signed-overflow flag (used for the ADD/SUB exception). A single clocked element, a sticky overflow status bit, provides the block's clock/reset behaviour; the datapath itself has no latency.

## Interface
- No parameters; data width fixed at 32, opcode width fixed at 5.
- clk  input  1  system clock; only the sticky status register uses it.
- rst  input  1  synchronous, active-high reset.
- srcA  input  32  operand A; also supplies the shift amount in srcA[4:0].
- srcB  input  32  operand B; the value being shifted, and the LUI source.
- ALUOPCtrl  input  5  operation select; encodings come from the shared opcode constants.
- zero  output  1  high when aluout == 32'h0.
- ovf  output  1  signed overflow of ADD/SUB; 0 for all other ops.
- aluout  output  32  result.
- ovf_sticky  output  1  registered; set by any cycle with ovf=1, cleared only by rst.

## Operation
- Opcode encodings (decimal):
  - 0 ADD: A+B, signed.
  - 1 ADDU: A+B, no ovf.
  - 2 SUB: A−B, signed.
  - 3 SUBU: A−B, no ovf.
  - 4 AND, 5 OR, 6 XOR, 7 NOR: bitwise.
  - 8 SLT: {31'b0, signed A<B}.
  - 9 SLTU: {31'b0, unsigned A<B}.
  - 10 SLL: B<<A[4:0].
  - 11 SRL: B>>A[4:0], logical.
  - 12 SRA: B>>>A[4:0], arithmetic.
  - 13 LUI: {B[15:0],16'h0}.
- Codes 14–31 are undefined: aluout=0, ovf=0, zero=1.
- Sums and differences wrap modulo 2^32; aluout always carries the wrapped result, even when ovf=1.
- ADD ovf = (A[31]==B[31]) && (sum[31]!=A[31]).
- SUB ovf = (A[31]!=B[31]) && (diff[31]!=A[31]).
- SLT compares true signed values, not the sign of the possibly overflowed difference; SLT of 0x80000000 vs 0x00000001 gives 1.
- Shift amounts use only A[4:0]; A[31:5] are ignored, so a shift by 32 acts as a shift by 0.
- zero is derived from aluout for every op, including SLT/SLTU.

## Timing
- aluout, zero and ovf are purely combinational from srcA/srcB/ALUOPCtrl: zero-cycle latency, settled within one clk period.
- ovf_sticky:
  - Reset value 0.
  - On a posedge clk with rst=1 it becomes 0; rst has priority over a simultaneous ovf=1.
  - Otherwise it becomes ovf_sticky | ovf.
- rst has no effect on the combinational outputs.
- Operands that change mid-cycle require no handshake; only the value present at posedge matters for ovf_sticky.

## Structure
- Shared package/include (ALUOPCtrl_Def): the 5-bit opcode localparams listed above, also used by the control decoder.
- One natural sub-module, alu_shifter (SLL/SRL/SRA barrel shifter, 32-bit value, 5-bit amount, 2-bit type).
- Add/sub logic, compare, logic ops, LUI and the result mux stay in the top module.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> aluout=0x80000000, ovf=1, zero=0; the following posedge sets ovf_sticky=1.
- ADDU with the same operands -> aluout=0x80000000, ovf=0.
- SUB 0x00000005 − 0x00000005 -> aluout=0, zero=1, ovf=0.
- SUB 0x80000000 − 0x00000001 -> aluout=0x7FFFFFFF, ovf=1.
- SLT 0x80000000 vs 0x00000001 -> 1.
- SLTU with the same operands -> 0, zero=1.
- SRA B=0xF0000000, A=4 -> 0xFF000000.
- SRL with the same operands -> 0x0F000000.
- SLL B=1, A=0x00000021 -> 0x00000002.
- LUI B=0x00001234 -> 0x12340000.
- NOR 0,0 -> 0xFFFFFFFF.
- Opcode 31 -> aluout=0, zero=1.
- rst=1 together with ovf=1 at a posedge -> ovf_sticky=0.
- File-driven sweep of random operands across all opcodes, compared against a golden model on every posedge.
